// File: rtl/channel_demux_pkg.sv
// Shared constants and types for the four-way channel demultiplexer.
package channel_demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;
endpackage

// File: rtl/channel_demux_if.sv
// Input and per-channel output handshakes of the demux.
// The master side is the producer/consumer environment; the slave side is the demux.
interface channel_demux_if
  import channel_demux_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic                           in_valid;
  logic                           in_ready;
  ch_sel_t                        in_sel;
  logic [WIDTH-1:0]               in_data;
  logic [NUM_CH-1:0]              out_valid;
  logic [NUM_CH-1:0]              out_ready;
  logic [NUM_CH-1:0][WIDTH-1:0]   out_data;   // channel k at [k*WIDTH +: WIDTH]

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/channel_demux_slot.sv
// One-entry holding register for a single output channel.
// A load wins over a drain, so a same-cycle drain+load keeps valid high.
module chan_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // Capture on load; on a bare drain only valid drops, data is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/channel_demux.sv
// Four-way demux: steers each accepted word into one per-channel slot,
// addressed by in_sel or by an internal round-robin pointer.
module channel_demux
  import channel_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  auto_mode,
  channel_demux_if.slave        bus,
  output ch_sel_t               rr_ptr
);

  ch_sel_t           dst;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;

  // Destination and readiness come from slot state only, never from in_valid.
  assign dst        = auto_mode ? rr_ptr : bus.in_sel;
  assign bus.in_ready = ~bus.out_valid[dst] | bus.out_ready[dst];
  assign accept     = bus.in_valid & bus.in_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_slot
      assign load[k]  = accept & (dst == ch_sel_t'(k));
      assign drain[k] = bus.out_valid[k] & bus.out_ready[k];

      chan_slot #(.WIDTH(WIDTH)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[k]),
        .drain (drain[k]),
        .din   (bus.in_data),
        .valid (bus.out_valid[k]),
        .dout  (bus.out_data[k])
      );
    end
  endgenerate

  // Round-robin pointer advances only on auto-mode accepts; wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rr_ptr <= '0;
    else if (accept && auto_mode) rr_ptr <= rr_ptr + ch_sel_t'(1);
  end

endmodule

// File: doc/channel_demux.md
# channel_demux

Four-way sequential demultiplexer that is the receive-side counterpart of the team's 4:1 selector. Each accepted input word is steered into one of four per-channel one-entry output registers, chosen either by a 2-bit select that travels with the word or by an internal round-robin counter. Used between a shared TDC sample bus and the per-channel downstream logic, with valid/ready back-pressure on every port.

## Interface
- WIDTH, 8: data word width in bits (1..32).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- auto_mode  input  1  1: destination from internal round-robin counter; 0: destination from in_sel.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word this cycle.
- in_sel  input  2  destination channel (0..3) when auto_mode=0; ignored otherwise.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: channel k consumer takes the word this cycle.
- out_data  output  4*WIDTH  channel k word in bits [k*WIDTH +: WIDTH].
- rr_ptr  output  2  current round-robin destination (debug/status).

## Operation
- Destination dst = auto_mode ? rr_ptr : in_sel, evaluated combinationally each cycle.
- in_ready = ~out_valid[dst] | out_ready[dst]; depends only on register state, auto_mode, in_sel, out_ready; never on in_valid.
- Accept = in_valid & in_ready. On accept: slot dst loads in_data, out_valid[dst] set.
- Slot k drain: out_valid[k] & out_ready[k] with no load to k -> out_valid[k] cleared; out_data[k] holds last value (not zeroed).
- Simultaneous drain and load on same slot: new word loaded, out_valid stays 1, no bubble.
- Loads and drains on different slots in same cycle are independent.
- Stall: in_valid with dst full and out_ready[dst]=0 -> in_ready=0, nothing changes; other slots keep draining. No word is dropped or duplicated.
- Round-robin: rr_ptr increments by 1 modulo 4 (3 -> 0) on each accept while auto_mode=1; holds otherwise, including across auto_mode toggles.
- auto_mode may change any cycle; takes effect on the dst of that same cycle.

## Timing
- Reset (async assert, sync-safe release): out_valid=4'b0000, out_data=all zeros, rr_ptr=0. in_ready=1 after reset (all slots empty).
- Latency: word accepted at edge N appears on out_data/out_valid at edge N (visible cycle N+1); one-cycle register latency.
- Throughput: one word per cycle sustained when the addressed consumer holds out_ready=1 or the addressed slot is empty.
- Consumer rule: out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
- Reset mid-operation: all pending slot contents discarded, out_valid cleared immediately (asynchronously); rr_ptr returns to 0.

## Structure
- Package channel_demux_pkg: NUM_CH=4, SEL_W=2, typedef logic [SEL_W-1:0] ch_sel_t.
- Sub-module chan_slot: one-entry holding register with load, drain, valid, data; instantiated NUM_CH times by a generate loop.
- Top holds dst mux, in_ready logic, load decode, rr_ptr counter.

## Test plan
- Reset with rst_n=0 mid-cycle -> out_valid=0000, out_data=0, rr_ptr=0, in_ready=1 immediately.
- auto_mode=0, out_ready=1111, send 0xA0,0xA1,0xA2,0xA3 with in_sel 0,1,2,3 -> each appears one cycle later on its channel only, in_ready always 1.
- auto_mode=1, out_ready=1111, 6 back-to-back words 0x10..0x15 -> channels 0,1,2,3,0,1; rr_ptr ends at 2.
- auto_mode=0, out_ready[2]=0, two words to sel=2 -> first held in slot 2, in_ready=0 for second; word to sel=1 meanwhile accepted; raising out_ready[2] drains 1st and loads 2nd same cycle, out_valid[2] stays 1.
- Toggle auto_mode 1->0->1 with rr_ptr=3 and accepts in manual mode -> rr_ptr stays 3, next auto word goes to channel 3, then rr_ptr wraps to 0.
- Assert rst_n=0 with slots 0 and 3 full -> out_valid cleared asynchronously, no stale word after release.
